bri_sw_ctrl: RTL and testbench

BRI_SW_CTRL -- requirements
Module: bri_sw_ctrl

---
 rtl/bri_pkg.sv | 19 +
 rtl/bri_dt_cnt.sv | 41 ++++
 rtl/bri_sw_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bri_sw_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bri_pkg.sv
// -----------------------------------------------------------------------------
// bri_pkg
// Shared definitions for the bank-switch controller: default widths of the
// dead-time input and the drain/run timeout counter, plus the FSM state
// encoding that is also exported on the debug port.
// -----------------------------------------------------------------------------
package bri_pkg;

  localparam int DT_W_DEF = 8;   // dead-time count width
  localparam int TO_W_DEF = 16;  // timeout counter width (timeout = 2^W-1)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DEAD  = 2'd3
  } bri_state_e;

endpackage

// File: rtl/bri_dt_cnt.sv
// -----------------------------------------------------------------------------
// bri_dt_cnt
// Loadable down-counter that saturates at zero. Used for both the dead-time
// blanking interval and the drain/run watchdog.
//   i_clk       clock
//   i_rst       synchronous reset, active-high (count -> 0)
//   i_load      load i_load_val (has priority over i_dec)
//   i_load_val  value to load
//   i_dec       decrement by one when non-zero
//   o_is_one    registered count equals 1 (last cycle of the interval)
// -----------------------------------------------------------------------------
module bri_dt_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_is_one
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  // Derived from the register only, so no input reaches the consumer
  // combinationally through this flag.
  assign o_is_one = (r_count == ONE);

endmodule

// File: rtl/bri_sw_ctrl.sv
// -----------------------------------------------------------------------------
// bri_sw_ctrl
// Controls two pulse-generator banks sharing one power stage. Selects the
// active bank, issues start pulses to it, and performs a blanked bank switch:
// drain the active bank, flip the mux select, hold blanking for the dead time.
//   clk_sys   system clock
//   rst       synchronous reset, active-high
//   sw_req    one-cycle switch request to bank sel_req (1 = bank 1, 0 = bank 2)
//   run_req   one-cycle request to start the active bank
//   busy1/2   bank sequence-active flags
//   deadtime  blanking cycles after a switch (0 behaves as 1)
//   change    mux select, 1 = bank 1
//   start1/2  one-cycle start pulses
//   blank     high while a switch is in progress
//   sw_ack    one-cycle switch-complete pulse
//   err       one-cycle reject / timeout pulse
//   state_o   current FSM state
// -----------------------------------------------------------------------------
module bri_sw_ctrl #(
  parameter int DT_W = bri_pkg::DT_W_DEF,
  parameter int TO_W = bri_pkg::TO_W_DEF
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            sw_req,
  input  logic            sel_req,
  input  logic            run_req,
  input  logic            busy1,
  input  logic            busy2,
  input  logic [DT_W-1:0] deadtime,
  output logic            change,
  output logic            start1,
  output logic            start2,
  output logic            blank,
  output logic            sw_ack,
  output logic            err,
  output logic [1:0]      state_o
);

  import bri_pkg::*;

  bri_state_e r_state;
  logic       r_change;
  logic       r_start1;
  logic       r_start2;
  logic       r_blank;
  logic       r_sw_ack;
  logic       r_err;
  logic       r_seen_busy;   // RUN: active bank has raised busy

  logic            w_active_busy;
  logic            w_idle;
  logic            w_sw_go;
  logic            w_run_go;
  logic            w_run_rise;
  logic            w_to_load;
  logic            w_to_dec;
  logic            w_to_one;
  logic            w_drain_exit;
  logic [DT_W-1:0] w_dt_val;
  logic            w_dt_dec;
  logic            w_dt_one;
  logic            w_req_outside;

  // Busy of the bank currently driving the output (the one being left while
  // in DRAIN).
  assign w_active_busy = r_change ? busy1 : busy2;
  assign w_idle        = (r_state == ST_IDLE);
  assign w_sw_go       = w_idle && sw_req && (sel_req != r_change);
  assign w_run_go      = w_idle && !sw_req && run_req && !w_active_busy;
  assign w_run_rise    = (r_state == ST_RUN) && !r_seen_busy && w_active_busy;
  assign w_req_outside = !w_idle && (sw_req || run_req);

  // Watchdog restarts at each wait phase: entering DRAIN, entering RUN, and
  // when RUN moves from waiting-for-rise to waiting-for-fall.
  assign w_to_load = w_sw_go || w_run_go || w_run_rise;
  assign w_to_dec  = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_run_rise;

  assign w_drain_exit = (r_state == ST_DRAIN) && (!w_active_busy || w_to_one);
  assign w_dt_val     = (deadtime == '0) ? DT_W'(1) : deadtime;
  assign w_dt_dec     = (r_state == ST_DEAD);

  bri_dt_cnt #(.W(TO_W)) u_to_cnt (
    .i_clk      (clk_sys),
    .i_rst      (rst),
    .i_load     (w_to_load),
    .i_load_val ({TO_W{1'b1}}),
    .i_dec      (w_to_dec),
    .o_is_one   (w_to_one)
  );

  bri_dt_cnt #(.W(DT_W)) u_dt_cnt (
    .i_clk      (clk_sys),
    .i_rst      (rst),
    .i_load     (w_drain_exit),
    .i_load_val (w_dt_val),
    .i_dec      (w_dt_dec),
    .o_is_one   (w_dt_one)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_change    <= 1'b1;
      r_start1    <= 1'b0;
      r_start2    <= 1'b0;
      r_blank     <= 1'b0;
      r_sw_ack    <= 1'b0;
      r_err       <= 1'b0;
      r_seen_busy <= 1'b0;
    end else begin
      r_start1 <= 1'b0;
      r_start2 <= 1'b0;
      r_sw_ack <= 1'b0;
      r_err    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (sw_req) begin
            if (sel_req == r_change) begin
              r_sw_ack <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
              r_blank <= 1'b1;
            end
            // Simultaneous run request loses to the switch.
            if (run_req) r_err <= 1'b1;
          end else if (run_req) begin
            if (w_active_busy) begin
              r_err <= 1'b1;
            end else begin
              r_start1    <= r_change;
              r_start2    <= !r_change;
              r_state     <= ST_RUN;
              r_seen_busy <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (!r_seen_busy) begin
            if (w_active_busy) begin
              r_seen_busy <= 1'b1;
            end else if (w_to_one) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else if (!w_active_busy) begin
            r_state <= ST_IDLE;
          end else if (w_to_one) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (w_drain_exit) begin
            r_change <= !r_change;
            r_state  <= ST_DEAD;
            // Leaving with busy still high means the watchdog fired.
            if (w_active_busy) r_err <= 1'b1;
          end
        end

        ST_DEAD: begin
          if (w_dt_one) begin
            r_state  <= ST_IDLE;
            r_blank  <= 1'b0;
            r_sw_ack <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      // Requests arriving while busy are dropped, never queued.
      if (w_req_outside) r_err <= 1'b1;
    end
  end

  assign change  = r_change;
  assign start1  = r_start1;
  assign start2  = r_start2;
  assign blank   = r_blank;
  assign sw_ack  = r_sw_ack;
  assign err     = r_err;
  assign state_o = r_state;

endmodule

// File: tb/tb_bri_sw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bri_sw_ctrl
// Directed bench for bri_sw_ctrl with a short watchdog (TO_W = 4, so the
// timeout is 15 cycles). Inputs change 1 ns after a rising edge; outputs are
// examined at the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_bri_sw_ctrl;

  localparam int DT_W = 8;
  localparam int TO_W = 4;

  logic            clk_sys = 1'b0;
  logic            rst     = 1'b1;
  logic            sw_req  = 1'b0;
  logic            sel_req = 1'b0;
  logic            run_req = 1'b0;
  logic            busy1   = 1'b0;
  logic            busy2   = 1'b0;
  logic [DT_W-1:0] deadtime = '0;
  logic            change;
  logic            start1;
  logic            start2;
  logic            blank;
  logic            sw_ack;
  logic            err;
  logic [1:0]      state_o;

  int checks = 0;
  int errors = 0;

  bri_sw_ctrl #(.DT_W(DT_W), .TO_W(TO_W)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .sw_req   (sw_req),
    .sel_req  (sel_req),
    .run_req  (run_req),
    .busy1    (busy1),
    .busy2    (busy2),
    .deadtime (deadtime),
    .change   (change),
    .start1   (start1),
    .start2   (start2),
    .blank    (blank),
    .sw_ack   (sw_ack),
    .err      (err),
    .state_o  (state_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Takes the request edge, then follows the switch until blank drops.
  // busy1/busy2 are cleared after sample number 'hold' (0 = never).
  task automatic run_switch(input int hold, output int nblank, output int ndrain,
                            output int ndead, output int nack, output int nerr,
                            output int nstart, output int done);
    nblank = 0; ndrain = 0; ndead = 0; nack = 0; nerr = 0; nstart = 0; done = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 1) begin
        sw_req  = 1'b0;
        run_req = 1'b0;
      end
      if (blank)          nblank++;
      if (state_o == 2)   ndrain++;
      if (state_o == 3)   ndead++;
      if (sw_ack)         nack++;
      if (err)            nerr++;
      if (start1 || start2) nstart++;
      if (i == hold) begin
        busy1 = 1'b0;
        busy2 = 1'b0;
      end
      if (!blank) begin
        done = 1;
        break;
      end
    end
  endtask

  initial begin
    int nb, nd, ndd, na, ne, ns, dn, n;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", state_o, 0);
    chk("rst_change", change, 1);
    chk("rst_blank", blank, 0);
    chk("rst_start", {start1, start2}, 0);
    chk("rst_ack_err", {sw_ack, err}, 0);
    $display("reset: state=%0d change=%0d", state_o, change);

    // Switch to bank 2, deadtime 5, bank 1 idle
    deadtime = 8'd5; sel_req = 1'b0; sw_req = 1'b1;
    run_switch(0, nb, nd, ndd, na, ne, ns, dn);
    chk("sw1_done", dn, 1);
    chk("sw1_blank", nb, 6);
    chk("sw1_drain", nd, 1);
    chk("sw1_dead", ndd, 5);
    chk("sw1_ack", na, 1);
    chk("sw1_err", ne, 0);
    chk("sw1_change", change, 0);
    $display("switch->2 dt=5: blank=%0d drain=%0d dead=%0d ack=%0d", nb, nd, ndd, na);

    // Request the bank already selected: immediate ack
    sw_req = 1'b1; sel_req = 1'b0;
    tick();
    sw_req = 1'b0;
    chk("same_ack", sw_ack, 1);
    chk("same_state", state_o, 0);
    chk("same_blank", blank, 0);
    tick();
    chk("same_ack_clr", sw_ack, 0);
    $display("same-bank request: acked");

    // Back to bank 1 with deadtime 0
    deadtime = 8'd0; sel_req = 1'b1; sw_req = 1'b1;
    run_switch(0, nb, nd, ndd, na, ne, ns, dn);
    chk("sw2_blank", nb, 2);
    chk("sw2_dead", ndd, 1);
    chk("sw2_ack", na, 1);
    chk("sw2_change", change, 1);
    $display("switch->1 dt=0: blank=%0d dead=%0d", nb, ndd);

    // Run on bank 1, busy high for 3 cycles, stray sw_req mid-run
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("run_start1", start1, 1);
    chk("run_start2", start2, 0);
    chk("run_state", state_o, 1);
    busy1 = 1'b1;
    tick();
    chk("run_start1_clr", start1, 0);
    sw_req = 1'b1; sel_req = 1'b0;
    tick();
    sw_req = 1'b0;
    chk("run_stray_err", err, 1);
    chk("run_stray_state", state_o, 1);
    chk("run_stray_blank", blank, 0);
    tick();
    chk("run_err_clr", err, 0);
    chk("run_busy_state", state_o, 1);
    busy1 = 1'b0;
    tick();
    chk("run_done_state", state_o, 0);
    chk("run_done_start", {start1, start2}, 0);
    $display("run bank1: returned to idle, change=%0d", change);

    // Run rejected while active bank busy
    busy1 = 1'b1; run_req = 1'b1;
    tick();
    run_req = 1'b0; busy1 = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_start", start1, 0);
    chk("rej_state", state_o, 0);
    tick();
    chk("rej_err_clr", err, 0);
    $display("run reject: err seen");

    // Run timeout: busy never rises, err on the 16th edge
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    n = 0;
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (err) begin
        n = i;
        break;
      end
    end
    chk("run_to_edge", n, 16);
    chk("run_to_state", state_o, 0);
    $display("run timeout: err at edge %0d", n);

    // Switch to bank 2 while bank 1 busy for 10 cycles
    deadtime = 8'd3; busy1 = 1'b1; sel_req = 1'b0; sw_req = 1'b1;
    run_switch(10, nb, nd, ndd, na, ne, ns, dn);
    chk("drain10_drain", nd, 10);
    chk("drain10_blank", nb, 13);
    chk("drain10_dead", ndd, 3);
    chk("drain10_err", ne, 0);
    chk("drain10_change", change, 0);
    $display("switch with drain: drain=%0d blank=%0d", nd, nb);

    // Switch and run requested together
    deadtime = 8'd2; sel_req = 1'b1; sw_req = 1'b1; run_req = 1'b1;
    run_switch(0, nb, nd, ndd, na, ne, ns, dn);
    chk("both_blank", nb, 3);
    chk("both_err", ne, 1);
    chk("both_start", ns, 0);
    chk("both_ack", na, 1);
    chk("both_change", change, 1);
    $display("switch+run: err=%0d start=%0d", ne, ns);

    // Drain timeout with busy1 stuck, deadtime 0
    deadtime = 8'd0; busy1 = 1'b1; sel_req = 1'b0; sw_req = 1'b1;
    run_switch(0, nb, nd, ndd, na, ne, ns, dn);
    busy1 = 1'b0;
    chk("dto_drain", nd, 15);
    chk("dto_dead", ndd, 1);
    chk("dto_blank", nb, 16);
    chk("dto_err", ne, 1);
    chk("dto_ack", na, 1);
    chk("dto_change", change, 0);
    $display("drain timeout: drain=%0d err=%0d ack=%0d", nd, ne, na);

    // Reset in DEAD, with a run request also present
    deadtime = 8'd5; sel_req = 1'b1; sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    tick(); tick();
    chk("pre_rst_state", state_o, 3);
    rst = 1'b1; run_req = 1'b1;
    tick();
    chk("mid_rst_change", change, 1);
    chk("mid_rst_blank", blank, 0);
    chk("mid_rst_ack", sw_ack, 0);
    chk("mid_rst_state", state_o, 0);
    tick();
    chk("mid_rst_start", start1, 0);
    rst = 1'b0; run_req = 1'b0;
    $display("reset in DEAD: change=%0d blank=%0d", change, blank);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
